// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: opaque payload, valid/ready handshake, 2-entry skid buffer, sync flush.
// Optional saturating stall/bubble perf counters when PIPE_REG_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 256,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("pipe_stage_reg: DATA_W must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W must be >= 1");
    end

    logic              mv, sv;
    logic [DATA_W-1:0] md, sd;
    logic              in_fire, out_fire;

    // in_ready comes straight from the skid flop, so back-pressure never ripples combinationally
    assign in_ready  = ~sv;
    assign in_fire   = in_valid & ~sv;
    assign out_fire  = mv & out_ready;
    assign out_valid = mv;
    assign out_data  = mv ? md : BUBBLE_VAL;
    assign occupancy = {1'b0, mv} + {1'b0, sv};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mv <= 1'b0;
            sv <= 1'b0;
            md <= BUBBLE_VAL;
            sd <= BUBBLE_VAL;
        end else if (clr) begin
            mv <= 1'b0;
            sv <= 1'b0;
            md <= BUBBLE_VAL;
            sd <= BUBBLE_VAL;
        end else if (!mv) begin
            if (in_fire) begin
                md <= in_data;
                mv <= 1'b1;
            end
        end else if (!sv) begin
            if (in_fire && out_fire) begin
                md <= in_data;
            end else if (out_fire) begin
                mv <= 1'b0;
                md <= BUBBLE_VAL;
            end else if (in_fire) begin
                sd <= in_data;
                sv <= 1'b1;
            end
        end else if (out_fire) begin
            // Full: drain skid into main; upstream is stalled this cycle
            md <= sd;
            sv <= 1'b0;
            sd <= BUBBLE_VAL;
        end
    end

`ifdef PIPE_REG_PERF_EN
    // Counters survive clr on purpose so flushes do not hide stall history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (mv && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!mv && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
